// File: rtl/mmu_cp0_regs.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | mmu_cp0_regs: CP0 MMU register file and TLBR/TLBWI/TLBWR/TLBP sequencer |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module mmu_cp0_regs #(
  parameter int TLB_ENTRIES = 16,
  parameter int IDX_W       = 4
) (
  input  logic             clk,
  input  logic             res_n,
  input  logic [3:0]       mmu_reg,
  input  logic             readMMUReg,
  input  logic             writeMMUReg,
  input  logic [31:0]      mmu_dataIn,
  output logic [31:0]      mmu_dataOut,
  input  logic [1:0]       tlb_op,
  input  logic             tlb_op_valid,
  output logic             tlb_busy,
  input  logic             exc_we,
  input  logic [31:0]      exc_badVAddr,
  output logic             tlb_req,
  output logic             tlb_we,
  output logic             tlb_probe,
  output logic [IDX_W-1:0] tlb_idx,
  output logic [31:0]      tlb_wdata_hi,
  output logic [31:0]      tlb_wdata_lo0,
  output logic [31:0]      tlb_wdata_lo1,
  output logic [31:0]      tlb_wdata_mask,
  input  logic             tlb_ack,
  input  logic [31:0]      tlb_rdata_hi,
  input  logic [31:0]      tlb_rdata_lo0,
  input  logic [31:0]      tlb_rdata_lo1,
  input  logic [31:0]      tlb_rdata_mask,
  input  logic             tlb_hit,
  input  logic [IDX_W-1:0] tlb_hit_idx
);

  // Register select encoding follows the CP0 register numbers
  localparam logic [3:0] MMU_REG_INDEX    = 4'd0;
  localparam logic [3:0] MMU_REG_RANDOM   = 4'd1;
  localparam logic [3:0] MMU_REG_ENTRYLO0 = 4'd2;
  localparam logic [3:0] MMU_REG_ENTRYLO1 = 4'd3;
  localparam logic [3:0] MMU_REG_CTX      = 4'd4;
  localparam logic [3:0] MMU_REG_PAGEMASK = 4'd5;
  localparam logic [3:0] MMU_REG_WIRED    = 4'd6;
  localparam logic [3:0] MMU_REG_ENTRYHI  = 4'd10;

  localparam logic [1:0] c_op_tlbr  = 2'd0;
  localparam logic [1:0] c_op_tlbwi = 2'd1;
  localparam logic [1:0] c_op_tlbwr = 2'd2;
  localparam logic [1:0] c_op_tlbp  = 2'd3;

  localparam logic [IDX_W-1:0] c_rand_max = IDX_W'(TLB_ENTRIES - 1);

  typedef enum logic [0:0] {S_IDLE = 1'b0, S_OP = 1'b1} state_t;

  state_t            r_state, w_next;
  logic [1:0]        r_op;
  logic              r_index_p;
  logic [IDX_W-1:0]  r_index, r_random, r_wired;
  logic [29:0]       r_lo0, r_lo1;
  logic [8:0]        r_ptebase;
  logic [18:0]       r_badvpn2;
  logic [15:0]       r_pagemask;
  logic [18:0]       r_vpn2;
  logic [7:0]        r_asid;

  logic [31:0] w_index, w_random, w_lo0, w_lo1, w_ctx, w_pagemask, w_wired, w_entryhi;
  logic [31:0] w_rd_data;
  logic        w_start, w_done, w_done_tlbr, w_done_tlbp;
  logic        w_wr_index, w_wr_lo0, w_wr_lo1, w_wr_ctx, w_wr_pm, w_wr_wired, w_wr_ehi;
  logic        w_unused;

  // Architectural views: unimplemented bits read as zero
  assign w_index    = {r_index_p, {(31-IDX_W){1'b0}}, r_index};
  assign w_random   = {{(32-IDX_W){1'b0}}, r_random};
  assign w_lo0      = {2'b00, r_lo0};
  assign w_lo1      = {2'b00, r_lo1};
  assign w_ctx      = {r_ptebase, r_badvpn2, 4'b0000};
  assign w_pagemask = {3'b000, r_pagemask, 13'b0};
  assign w_wired    = {{(32-IDX_W){1'b0}}, r_wired};
  assign w_entryhi  = {r_vpn2, 5'b00000, r_asid};

  always_comb begin
    w_rd_data = 32'h0;
    case (mmu_reg)
      MMU_REG_INDEX:    w_rd_data = w_index;
      MMU_REG_RANDOM:   w_rd_data = w_random;
      MMU_REG_ENTRYLO0: w_rd_data = w_lo0;
      MMU_REG_ENTRYLO1: w_rd_data = w_lo1;
      MMU_REG_CTX:      w_rd_data = w_ctx;
      MMU_REG_PAGEMASK: w_rd_data = w_pagemask;
      MMU_REG_WIRED:    w_rd_data = w_wired;
      MMU_REG_ENTRYHI:  w_rd_data = w_entryhi;
      default:          w_rd_data = 32'h0;
    endcase
  end

  assign w_wr_index = writeMMUReg && (mmu_reg == MMU_REG_INDEX);
  assign w_wr_lo0   = writeMMUReg && (mmu_reg == MMU_REG_ENTRYLO0);
  assign w_wr_lo1   = writeMMUReg && (mmu_reg == MMU_REG_ENTRYLO1);
  assign w_wr_ctx   = writeMMUReg && (mmu_reg == MMU_REG_CTX);
  assign w_wr_pm    = writeMMUReg && (mmu_reg == MMU_REG_PAGEMASK);
  assign w_wr_wired = writeMMUReg && (mmu_reg == MMU_REG_WIRED);
  assign w_wr_ehi   = writeMMUReg && (mmu_reg == MMU_REG_ENTRYHI);

  assign w_start     = (r_state == S_IDLE) && tlb_op_valid;
  assign w_done      = (r_state == S_OP) && tlb_ack;
  assign w_done_tlbr = w_done && (r_op == c_op_tlbr);
  assign w_done_tlbp = w_done && (r_op == c_op_tlbp);
  assign tlb_busy    = (r_state == S_OP);

  assign w_unused = ^{mmu_dataIn, exc_badVAddr, tlb_rdata_hi, tlb_rdata_lo0,
                      tlb_rdata_lo1, tlb_rdata_mask};

  always_ff @(posedge clk or negedge res_n) begin
    if (!res_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (tlb_op_valid) w_next = S_OP;
      S_OP:    if (tlb_ack) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // TLB request side: index and entry data are frozen for the whole request
  always_ff @(posedge clk or negedge res_n) begin
    if (!res_n) begin
      r_op           <= c_op_tlbr;
      tlb_req        <= 1'b0;
      tlb_we         <= 1'b0;
      tlb_probe      <= 1'b0;
      tlb_idx        <= '0;
      tlb_wdata_hi   <= 32'h0;
      tlb_wdata_lo0  <= 32'h0;
      tlb_wdata_lo1  <= 32'h0;
      tlb_wdata_mask <= 32'h0;
    end else if (w_start) begin
      r_op           <= tlb_op;
      tlb_req        <= 1'b1;
      tlb_we         <= (tlb_op == c_op_tlbwi) || (tlb_op == c_op_tlbwr);
      tlb_probe      <= (tlb_op == c_op_tlbp);
      tlb_idx        <= (tlb_op == c_op_tlbwr) ? r_random : r_index;
      tlb_wdata_hi   <= w_entryhi;
      tlb_wdata_lo0  <= w_lo0;
      tlb_wdata_lo1  <= w_lo1;
      tlb_wdata_mask <= w_pagemask;
    end else if (w_done) begin
      tlb_req   <= 1'b0;
      tlb_we    <= 1'b0;
      tlb_probe <= 1'b0;
    end
  end

  // Register file: per field, TLB completion beats exception capture beats software
  always_ff @(posedge clk or negedge res_n) begin
    if (!res_n) begin
      mmu_dataOut <= 32'h0;
      r_index_p   <= 1'b0;
      r_index     <= '0;
      r_random    <= c_rand_max;
      r_wired     <= '0;
      r_lo0       <= '0;
      r_lo1       <= '0;
      r_ptebase   <= '0;
      r_badvpn2   <= '0;
      r_pagemask  <= '0;
      r_vpn2      <= '0;
      r_asid      <= '0;
    end else begin
      if (readMMUReg) mmu_dataOut <= w_rd_data;

      if (w_done_tlbp) begin
        r_index_p <= !tlb_hit;
        r_index   <= tlb_hit ? tlb_hit_idx : '0;
      end else if (w_wr_index) begin
        r_index   <= mmu_dataIn[IDX_W-1:0];
      end

      if (w_wr_wired || (r_random <= r_wired)) r_random <= c_rand_max;
      else                                     r_random <= r_random - 1'b1;
      if (w_wr_wired) r_wired <= mmu_dataIn[IDX_W-1:0];

      if (w_done_tlbr)   r_lo0 <= tlb_rdata_lo0[29:0];
      else if (w_wr_lo0) r_lo0 <= mmu_dataIn[29:0];
      if (w_done_tlbr)   r_lo1 <= tlb_rdata_lo1[29:0];
      else if (w_wr_lo1) r_lo1 <= mmu_dataIn[29:0];
      if (w_done_tlbr)  r_pagemask <= tlb_rdata_mask[28:13];
      else if (w_wr_pm) r_pagemask <= mmu_dataIn[28:13];

      if (w_wr_ctx) r_ptebase <= mmu_dataIn[31:23];
      if (exc_we)   r_badvpn2 <= exc_badVAddr[31:13];

      if (w_done_tlbr)   r_vpn2 <= tlb_rdata_hi[31:13];
      else if (exc_we)   r_vpn2 <= exc_badVAddr[31:13];
      else if (w_wr_ehi) r_vpn2 <= mmu_dataIn[31:13];
      if (w_done_tlbr)   r_asid <= tlb_rdata_hi[7:0];
      else if (w_wr_ehi) r_asid <= mmu_dataIn[7:0];
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_mmu_cp0_regs.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_mmu_cp0_regs: self-checking bench for mmu_cp0_regs                 |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module tb_mmu_cp0_regs;

  localparam logic [3:0] R_INDEX = 4'd0,  R_RANDOM = 4'd1, R_LO0 = 4'd2, R_LO1 = 4'd3;
  localparam logic [3:0] R_CTX   = 4'd4,  R_PM     = 4'd5, R_WIRED = 4'd6;
  localparam logic [3:0] R_EHI   = 4'd10, R_NONE   = 4'd15;

  logic        clk = 1'b0;
  logic        res_n = 1'b0;
  logic [3:0]  mmu_reg = R_NONE;
  logic        readMMUReg = 1'b0, writeMMUReg = 1'b0;
  logic [31:0] mmu_dataIn = 32'h0;
  logic [31:0] mmu_dataOut;
  logic [1:0]  tlb_op = 2'd0;
  logic        tlb_op_valid = 1'b0;
  logic        tlb_busy;
  logic        exc_we = 1'b0;
  logic [31:0] exc_badVAddr = 32'h0;
  logic        tlb_req, tlb_we, tlb_probe;
  logic [3:0]  tlb_idx;
  logic [31:0] tlb_wdata_hi, tlb_wdata_lo0, tlb_wdata_lo1, tlb_wdata_mask;
  logic        tlb_ack = 1'b0;
  logic [31:0] tlb_rdata_hi = 32'h0, tlb_rdata_lo0 = 32'h0;
  logic [31:0] tlb_rdata_lo1 = 32'h0, tlb_rdata_mask = 32'h0;
  logic        tlb_hit = 1'b0;
  logic [3:0]  tlb_hit_idx = 4'd0;

  int errors = 0;
  int checks = 0;

  logic [31:0] exp_q[$];
  string       name_q[$];

  typedef struct {
    logic [3:0]  sel;
    bit          wr;
    bit          rd;
    logic [31:0] wdata;
    logic [31:0] exp;
  } vec_t;
  vec_t vecs[$];

  mmu_cp0_regs #(.TLB_ENTRIES(16), .IDX_W(4)) dut (
    .clk(clk), .res_n(res_n), .mmu_reg(mmu_reg), .readMMUReg(readMMUReg),
    .writeMMUReg(writeMMUReg), .mmu_dataIn(mmu_dataIn), .mmu_dataOut(mmu_dataOut),
    .tlb_op(tlb_op), .tlb_op_valid(tlb_op_valid), .tlb_busy(tlb_busy),
    .exc_we(exc_we), .exc_badVAddr(exc_badVAddr), .tlb_req(tlb_req), .tlb_we(tlb_we),
    .tlb_probe(tlb_probe), .tlb_idx(tlb_idx), .tlb_wdata_hi(tlb_wdata_hi),
    .tlb_wdata_lo0(tlb_wdata_lo0), .tlb_wdata_lo1(tlb_wdata_lo1),
    .tlb_wdata_mask(tlb_wdata_mask), .tlb_ack(tlb_ack), .tlb_rdata_hi(tlb_rdata_hi),
    .tlb_rdata_lo0(tlb_rdata_lo0), .tlb_rdata_lo1(tlb_rdata_lo1),
    .tlb_rdata_mask(tlb_rdata_mask), .tlb_hit(tlb_hit), .tlb_hit_idx(tlb_hit_idx)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
    end
  endtask

  // One clock; a read strobe driven before the edge is scored after it
  task automatic step();
    bit pend;
    pend = readMMUReg;
    @(posedge clk);
    #1;
    if (pend) begin
      if (exp_q.size() == 0) check("sb_underflow", 32'h1, 32'h0);
      else check(name_q.pop_front(), mmu_dataOut, exp_q.pop_front());
    end
  endtask

  task automatic rd(input logic [3:0] sel, input logic [31:0] exp, input string nm);
    mmu_reg = sel;
    readMMUReg = 1'b1;
    exp_q.push_back(exp);
    name_q.push_back(nm);
    step();
    readMMUReg = 1'b0;
  endtask

  task automatic wr(input logic [3:0] sel, input logic [31:0] d);
    mmu_reg = sel;
    mmu_dataIn = d;
    writeMMUReg = 1'b1;
    step();
    writeMMUReg = 1'b0;
  endtask

  task automatic add(input logic [3:0] s, input bit w, input bit r,
                     input logic [31:0] d, input logic [31:0] e);
    vec_t v;
    v.sel = s; v.wr = w; v.rd = r; v.wdata = d; v.exp = e;
    vecs.push_back(v);
  endtask

  initial begin
    int cnt;
    logic [31:0] rexp;

    add(R_INDEX, 0, 1, 32'h0, 32'h0);
    add(R_LO0,   0, 1, 32'h0, 32'h0);
    add(R_LO1,   0, 1, 32'h0, 32'h0);
    add(R_CTX,   0, 1, 32'h0, 32'h0);
    add(R_PM,    0, 1, 32'h0, 32'h0);
    add(R_WIRED, 0, 1, 32'h0, 32'h0);
    add(R_EHI,   0, 1, 32'h0, 32'h0);
    add(R_NONE,  0, 1, 32'h0, 32'h0);
    add(R_EHI,   1, 0, 32'hFFFFFFFF, 32'h0);
    add(R_EHI,   0, 1, 32'h0, 32'hFFFFE0FF);
    add(R_PM,    1, 0, 32'hFFFFFFFF, 32'h0);
    add(R_PM,    0, 1, 32'h0, 32'h1FFFE000);
    add(R_LO0,   1, 0, 32'hFFFFFFFF, 32'h0);
    add(R_LO0,   0, 1, 32'h0, 32'h3FFFFFFF);
    add(R_CTX,   1, 0, 32'hFFFFFFFF, 32'h0);
    add(R_CTX,   0, 1, 32'h0, 32'hFF800000);
    add(R_INDEX, 1, 0, 32'hFFFFFFFF, 32'h0);
    add(R_INDEX, 0, 1, 32'h0, 32'h0000000F);
    add(R_LO1,   1, 1, 32'hFFFFFFFF, 32'h0);        // same-cycle read sees old value
    add(R_LO1,   0, 1, 32'h0, 32'h3FFFFFFF);
    add(R_NONE,  1, 1, 32'hFFFFFFFF, 32'h0);

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_dataOut", mmu_dataOut, 32'h0);
    check("rst_req", {31'h0, tlb_req}, 32'h0);
    check("rst_busy", {31'h0, tlb_busy}, 32'h0);
    check("rst_idx", {28'h0, tlb_idx}, 32'h0);
    check("rst_wdata_hi", tlb_wdata_hi, 32'h0);
    res_n = 1'b1;
    rd(R_RANDOM, 32'h0000000F, "rst_random");

    foreach (vecs[i]) begin
      mmu_reg     = vecs[i].sel;
      mmu_dataIn  = vecs[i].wdata;
      writeMMUReg = vecs[i].wr;
      readMMUReg  = vecs[i].rd;
      if (vecs[i].rd) begin
        exp_q.push_back(vecs[i].exp);
        name_q.push_back($sformatf("vec%0d", i));
      end
      step();
      writeMMUReg = 1'b0;
      readMMUReg  = 1'b0;
    end

    // Random countdown with Wired = 3
    wr(R_WIRED, 32'h3);
    mmu_reg = R_RANDOM;
    readMMUReg = 1'b1;
    rexp = 32'd15;
    for (int i = 0; i < 15; i++) begin
      exp_q.push_back(rexp);
      name_q.push_back($sformatf("random_w3_%0d", i));
      step();
      rexp = (rexp <= 32'd3) ? 32'd15 : rexp - 32'd1;
    end
    readMMUReg = 1'b0;
    wr(R_WIRED, 32'hFFFFFFFF);
    rd(R_WIRED, 32'h0000000F, "wired_max");
    for (int i = 0; i < 3; i++) rd(R_RANDOM, 32'h0000000F, $sformatf("random_hold_%0d", i));

    // TLBWI with ack in the fourth busy cycle and a mid-op EntryHi rewrite
    wr(R_INDEX, 32'h5);
    wr(R_EHI, 32'h12345000);
    tlb_op = 2'd1;
    tlb_op_valid = 1'b1;
    step();
    tlb_op_valid = 1'b0;
    check("tlbwi_req", {31'h0, tlb_req}, 32'h1);
    check("tlbwi_we", {31'h0, tlb_we}, 32'h1);
    check("tlbwi_probe", {31'h0, tlb_probe}, 32'h0);
    check("tlbwi_idx", {28'h0, tlb_idx}, 32'h5);
    check("tlbwi_lo0", tlb_wdata_lo0, 32'h3FFFFFFF);
    check("tlbwi_mask", tlb_wdata_mask, 32'h1FFFE000);
    cnt = 0;
    while (tlb_busy && cnt < 20) begin
      cnt++;
      check($sformatf("tlbwi_hi_c%0d", cnt), tlb_wdata_hi, 32'h12344000);
      mmu_reg = R_EHI;
      mmu_dataIn = 32'hDEAD0000;
      writeMMUReg = (cnt == 2);
      tlb_ack = (cnt == 4);
      step();
      writeMMUReg = 1'b0;
      tlb_ack = 1'b0;
    end
    check("tlbwi_busy_cycles", cnt, 32'd4);
    check("tlbwi_req_after", {31'h0, tlb_req}, 32'h0);
    rd(R_EHI, 32'hDEAD0000, "tlbwi_ehi_midop");

    // TLBP hit with ack in the first request cycle
    tlb_op = 2'd3;
    tlb_op_valid = 1'b1;
    step();
    tlb_op_valid = 1'b0;
    check("tlbp_probe", {31'h0, tlb_probe}, 32'h1);
    check("tlbp_we", {31'h0, tlb_we}, 32'h0);
    tlb_ack = 1'b1; tlb_hit = 1'b1; tlb_hit_idx = 4'd7;
    step();
    tlb_ack = 1'b0;
    check("tlbp_busy_after", {31'h0, tlb_busy}, 32'h0);
    rd(R_INDEX, 32'h00000007, "tlbp_hit_index");

    // TLBP miss; a start pulse during OP must be ignored
    tlb_op_valid = 1'b1;
    step();
    check("tlbp2_idx", {28'h0, tlb_idx}, 32'h7);
    tlb_ack = 1'b1; tlb_hit = 1'b0;
    step();
    tlb_ack = 1'b0;
    tlb_op_valid = 1'b0;
    check("valid_in_op_ignored", {31'h0, tlb_busy}, 32'h0);
    rd(R_INDEX, 32'h80000000, "tlbp_miss_index");

    // TLBR ack collides with exc_we and an EntryHi write
    tlb_op = 2'd0;
    tlb_op_valid = 1'b1;
    step();
    tlb_op_valid = 1'b0;
    tlb_ack = 1'b1;
    tlb_rdata_hi = 32'hABCDE0FF; tlb_rdata_lo0 = 32'hC0000001;
    tlb_rdata_lo1 = 32'h12345678; tlb_rdata_mask = 32'hFFFFFFFF;
    exc_we = 1'b1; exc_badVAddr = 32'h55555000;
    mmu_reg = R_EHI; mmu_dataIn = 32'h11111011; writeMMUReg = 1'b1;
    step();
    tlb_ack = 1'b0; exc_we = 1'b0; writeMMUReg = 1'b0;
    rd(R_EHI, 32'hABCDE0FF, "tlbr_ehi");
    rd(R_LO0, 32'h00000001, "tlbr_lo0");
    rd(R_LO1, 32'h12345678, "tlbr_lo1");
    rd(R_PM,  32'h1FFFE000, "tlbr_pm");
    rd(R_CTX, 32'hFFAAAAA0, "tlbr_ctx_badvpn2");

    // exc_we owns VPN2, software write still lands ASID
    exc_we = 1'b1; exc_badVAddr = 32'h12346FFF;
    mmu_reg = R_EHI; mmu_dataIn = 32'h00000042; writeMMUReg = 1'b1;
    step();
    exc_we = 1'b0; writeMMUReg = 1'b0;
    rd(R_EHI, 32'h12346042, "exc_sw_ehi");
    rd(R_CTX, 32'hFF891A30, "exc_ctx");

    // TLBWR uses Random (held at 15 by Wired), then reset mid-op
    tlb_op = 2'd2;
    tlb_op_valid = 1'b1;
    step();
    tlb_op_valid = 1'b0;
    check("tlbwr_idx", {28'h0, tlb_idx}, 32'hF);
    check("tlbwr_we", {31'h0, tlb_we}, 32'h1);
    #2;
    res_n = 1'b0;
    #1;
    check("midrst_req", {31'h0, tlb_req}, 32'h0);
    check("midrst_busy", {31'h0, tlb_busy}, 32'h0);
    check("midrst_we", {31'h0, tlb_we}, 32'h0);
    check("midrst_idx", {28'h0, tlb_idx}, 32'h0);
    check("midrst_wdata_lo0", tlb_wdata_lo0, 32'h0);
    check("midrst_dataOut", mmu_dataOut, 32'h0);
    @(posedge clk);
    #1;
    res_n = 1'b1;
    rd(R_WIRED, 32'h0, "postrst_wired");
    tlb_op = 2'd1;
    tlb_op_valid = 1'b1;
    step();
    tlb_op_valid = 1'b0;
    check("postrst_req", {31'h0, tlb_req}, 32'h1);
    check("postrst_idx", {28'h0, tlb_idx}, 32'h0);
    tlb_ack = 1'b1;
    step();
    tlb_ack = 1'b0;
    check("postrst_busy_after", {31'h0, tlb_busy}, 32'h0);
    check("sb_drained", exp_q.size(), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
